mem_port_arbiter: RTL

Two-requester memory arbiter that shares the single unified instruction/data memory between the multi-cycle accumulator core's datapath memory port and a DMA/program-loader port. It sits between the datapath's memory address/data path and the memory array. It sequences each access through a fixed-latency memory. It returns a one-cycle ready pulse that the multi-cycle controller uses as a stall release. Arbitration is round-robin, so neither requester can starve the other.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// owner identifiers and the read-latency counter width.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int LAT_W = 3;

    // Terminal count of the latency counter for a given read latency.
    function automatic logic [LAT_W-1:0] lat_last(input int lat);
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker. A lone request always wins;
// on a tie the port that was not granted last is chosen.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the winner from the request vector (bit 0 = core, bit 1 = DMA).
    always_comb begin
        gnt_valid = |req;
        gnt_id    = OWN_CPU;
        case (req)
            2'b01:   gnt_id = OWN_CPU;
            2'b10:   gnt_id = OWN_DMA;
            2'b11:   gnt_id = ~last;
            default: gnt_id = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the core datapath port and the
// DMA/loader port. Each access runs IDLE -> ACCESS -> DONE; DONE gives the
// granted port a one-cycle ready pulse that releases the core's stall.
// All outputs come from registers or from decoding registered state, so
// no request input reaches a mem_* output combinationally.
module mem_port_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    import mem_port_arbiter_pkg::*;

    localparam logic [LAT_W-1:0] LAT_LAST = lat_last(MEM_LAT);

    arb_state_t        state;
    arb_state_t        state_n;
    logic              last;
    logic [LAT_W-1:0]  cnt;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              access_end;

    rr_arb2 u_rr_arb2 (
        .req       ({dma_req, cpu_req}),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Route the winning port's transaction fields toward the latch registers.
    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (gnt_id == OWN_DMA) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    // A write needs one memory cycle; a read waits out the full latency.
    assign access_end = we_q || (cnt == LAT_LAST);

    // State register; reset aborts any access in flight without a ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode: requests only matter while IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (gnt_valid) state_n = ACCESS;
            ACCESS:  if (access_end) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Latch the granted transaction and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last    <= OWN_DMA;
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && gnt_valid) begin
            last    <= gnt_id;
            owner_q <= gnt_id;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // Count ACCESS cycles so a read holds the memory for exactly MEM_LAT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == ACCESS) begin
            cnt <= cnt + LAT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Capture read data on the final ACCESS edge, when the memory output is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (state == ACCESS && !we_q && cnt == LAT_LAST) begin
            rdata_q <= mem_rdata;
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = (state == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;
    assign busy      = (state != IDLE);

    assign cpu_ready = (state == DONE) && (owner_q == OWN_CPU);
    assign dma_ready = (state == DONE) && (owner_q == OWN_DMA);
    assign cpu_rdata = cpu_ready ? rdata_q : '0;
    assign dma_rdata = dma_ready ? rdata_q : '0;

endmodule
